hpdcache_mem_write_responder: RTL and testbench

- Memory-side responder for the HPDcache write channel: the target end of the write-request, write-data and write-response interface that the cache's flush and write-buffer paths drive.
- Accepts a write header and then `len+1` data flits.
- Drives each flit onto a simple backing-store write port.
- Returns one write response per transaction, carrying the request ID.
- Used as a memory model in block and subsystem benches, and as the terminating target in FPGA bring-up.

---
 rtl/hpdcache_mem_write_responder_if.sv | 40 ++++
 rtl/hpdcache_mem_write_responder.sv | 156 +++++++++++++++
 tb/tb_hpdcache_mem_write_responder.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hpdcache_mem_write_responder_if.sv
// Write-channel bundle between the HPDcache (master) and the memory-side responder (slave).
// Every channel uses valid/ready: a transfer happens on the rising clock edge where valid and ready are both high.
// Once valid is raised, the source holds it and the payload steady until that transfer.
interface hpdcache_mem_write_responder_if #(
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64,
    parameter int IdWidth   = 4,
    parameter int LenWidth  = 8
);
    logic                     req_valid_i;
    logic                     req_ready_o;
    logic [AddrWidth-1:0]     req_addr_i;
    logic [LenWidth-1:0]      req_len_i;
    logic [IdWidth-1:0]       req_id_i;
    logic                     data_valid_i;
    logic                     data_ready_o;
    logic [DataWidth-1:0]     data_i;
    logic [DataWidth/8-1:0]   be_i;
    logic                     data_last_i;
    logic                     resp_valid_o;
    logic                     resp_ready_i;
    logic [IdWidth-1:0]       resp_id_o;
    logic                     resp_error_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_len_i, req_id_i,
        input  data_valid_i, data_i, be_i, data_last_i,
        input  resp_ready_i,
        output req_ready_o, data_ready_o,
        output resp_valid_o, resp_id_o, resp_error_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_len_i, req_id_i,
        output data_valid_i, data_i, be_i, data_last_i,
        output resp_ready_i,
        input  req_ready_o, data_ready_o,
        input  resp_valid_o, resp_id_o, resp_error_o
    );
endinterface

// File: rtl/hpdcache_mem_write_responder.sv
// Memory-side write target: takes a header plus len+1 flits, writes each flit to a backing-store port,
// and returns one in-order {id, error} response per transaction through a small FIFO.
module hpdcache_mem_write_responder #(
    parameter int AddrWidth     = 64,
    parameter int DataWidth     = 64,
    parameter int IdWidth       = 4,
    parameter int LenWidth      = 8,
    parameter int RespFifoDepth = 4
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    hpdcache_mem_write_responder_if.slave                 wr,
    output logic                                          mem_we_o,
    output logic [AddrWidth-$clog2(DataWidth/8)-1:0]      mem_addr_o,
    output logic [DataWidth-1:0]                          mem_wdata_o,
    output logic [DataWidth/8-1:0]                        mem_be_o,
    output logic                                          busy_o,
    output logic                                          dbg_state_o
);
    localparam int OffW   = $clog2(DataWidth/8);
    localparam int WAddrW = AddrWidth - OffW;
    localparam int BeW    = DataWidth/8;
    localparam int PtrW   = (RespFifoDepth > 1) ? $clog2(RespFifoDepth) : 1;
    localparam int CntW   = $clog2(RespFifoDepth + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_DATA = 1'b1;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic               err;
    } resp_t;

    logic [0:0]          state_q, state_d;
    logic [LenWidth-1:0] beat_q, beat_d;
    logic                err_q, err_d;
    logic [LenWidth-1:0] len_q;
    logic [IdWidth-1:0]  id_q;
    logic [WAddrW-1:0]   base_q;

    logic                mem_we_q;
    logic [WAddrW-1:0]   mem_addr_q;
    logic [DataWidth-1:0] mem_wdata_q;
    logic [BeW-1:0]      mem_be_q;

    resp_t               fifo_q [RespFifoDepth];
    logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]     cnt_q, cnt_d;

    logic req_ready, data_ready, req_hs, data_hs;
    logic last_beat, mismatch, push, pop;
    resp_t push_entry;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(RespFifoDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    // The response slot is reserved at header time, so a push can never meet a full FIFO.
    assign req_ready  = (state_q == ST_IDLE) && (cnt_q < CntW'(RespFifoDepth)) && !rst_i;
    assign data_ready = (state_q == ST_DATA);
    assign req_hs     = wr.req_valid_i & req_ready;
    assign data_hs    = wr.data_valid_i & data_ready;
    assign last_beat  = (beat_q == len_q);
    assign mismatch   = wr.data_last_i ^ last_beat;
    assign pop        = (cnt_q != '0) & wr.resp_ready_i;
    assign push_entry = '{id: id_q, err: err_q | mismatch};

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        err_d   = err_q;
        push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_hs) begin
                    state_d = ST_DATA;
                    beat_d  = '0;
                    err_d   = 1'b0;
                end
            end
            ST_DATA: begin
                // Completion is decided by the beat count alone; data_last_i only feeds the error flag.
                if (data_hs) begin
                    if (last_beat) begin
                        state_d = ST_IDLE;
                        push    = 1'b1;
                    end else begin
                        beat_d = beat_q + 1'b1;
                        err_d  = err_q | mismatch;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) cnt_d = cnt_q + 1'b1;
        else if (!push && pop) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            err_q       <= 1'b0;
            len_q       <= '0;
            id_q        <= '0;
            base_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            for (int i = 0; i < RespFifoDepth; i++) fifo_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            mem_we_q <= data_hs;
            if (req_hs) begin
                len_q  <= wr.req_len_i;
                id_q   <= wr.req_id_i;
                base_q <= wr.req_addr_i[AddrWidth-1:OffW];
            end
            // Word address wraps silently at the top of the address space.
            if (data_hs) begin
                mem_addr_q  <= base_q + WAddrW'(beat_q);
                mem_wdata_q <= wr.data_i;
                mem_be_q    <= wr.be_i;
            end
            if (push) begin
                fifo_q[wr_ptr_q] <= push_entry;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
    end

    assign wr.req_ready_o  = req_ready;
    assign wr.data_ready_o = data_ready;
    assign wr.resp_valid_o = (cnt_q != '0);
    assign wr.resp_id_o    = (cnt_q != '0) ? fifo_q[rd_ptr_q].id : '0;
    assign wr.resp_error_o = (cnt_q != '0) ? fifo_q[rd_ptr_q].err : 1'b0;

    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_be_o    = mem_be_q;
    assign busy_o      = (state_q != ST_IDLE) || (cnt_q != '0);
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_hpdcache_mem_write_responder.sv
// Bench for hpdcache_mem_write_responder: scenario tasks drive the write channel, a negedge
// monitor pops expected writes/responses from queues filled as stimulus is driven.
module tb_hpdcache_mem_write_responder;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int IW  = 4;
  localparam int LW  = 8;
  localparam int BW  = DW / 8;
  localparam int OW  = 3;
  localparam int WAW = AW - OW;
  localparam int WW  = WAW + DW + BW;
  localparam int RW  = IW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           mem_we_o;
  logic [WAW-1:0] mem_addr_o;
  logic [DW-1:0]  mem_wdata_o;
  logic [BW-1:0]  mem_be_o;
  logic           busy_o;
  logic           dbg_state_o;

  hpdcache_mem_write_responder_if #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .LenWidth(LW)) bus ();

  hpdcache_mem_write_responder #(
    .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .LenWidth(LW), .RespFifoDepth(4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .wr          (bus),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_be_o    (mem_be_o),
    .busy_o      (busy_o),
    .dbg_state_o (dbg_state_o)
  );

  int tests = 0;
  int fails = 0;
  logic [WW-1:0] exp_w_q[$];
  logic [RW-1:0] exp_r_q[$];

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin : monitor
    logic [WW-1:0] ew;
    logic [RW-1:0] er;
    if (!rst) begin
      if (mem_we_o) begin
        tests++;
        if (exp_w_q.size() == 0) begin
          fails++;
          $display("FAIL mem_write_unexpected got addr=%h data=%h be=%h", mem_addr_o, mem_wdata_o, mem_be_o);
        end else begin
          ew = exp_w_q.pop_front();
          if ({mem_addr_o, mem_wdata_o, mem_be_o} !== ew) begin
            fails++;
            $display("FAIL mem_write got addr=%h data=%h be=%h exp addr=%h data=%h be=%h",
                     mem_addr_o, mem_wdata_o, mem_be_o, ew[WW-1 -: WAW], ew[BW +: DW], ew[BW-1:0]);
          end
        end
      end
      if (bus.resp_valid_o && bus.resp_ready_i) begin
        tests++;
        if (exp_r_q.size() == 0) begin
          fails++;
          $display("FAIL resp_unexpected got id=%0d err=%0d", bus.resp_id_o, bus.resp_error_o);
        end else begin
          er = exp_r_q.pop_front();
          if ({bus.resp_id_o, bus.resp_error_o} !== er) begin
            fails++;
            $display("FAIL resp got id=%0d err=%0d exp id=%0d err=%0d",
                     bus.resp_id_o, bus.resp_error_o, er[RW-1:1], er[0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_hdr(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic [IW-1:0] id,
                          output int waits);
    bit hs = 0;
    waits = 0;
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = a;
    bus.req_len_i   = l;
    bus.req_id_i    = id;
    while (!hs && waits < 200) begin
      @(negedge clk);
      hs = bus.req_ready_o;
      @(posedge clk);
      #1;
      if (!hs) waits++;
    end
    bus.req_valid_i = 1'b0;
    tests++;
    if (!hs) begin
      fails++;
      $display("FAIL hdr_timeout id=%0d got no handshake exp handshake", id);
    end else begin
      tests++;
      if ({bus.req_ready_o, bus.data_ready_o, dbg_state_o} !== 3'b011) begin
        fails++;
        $display("FAIL hdr_state got req_rdy/data_rdy/state=%b exp 011",
                 {bus.req_ready_o, bus.data_ready_o, dbg_state_o});
      end
    end
  endtask

  task automatic send_flit(input logic [WAW-1:0] wa, input logic [DW-1:0] d, input logic [BW-1:0] be,
                           input logic last);
    bit hs = 0;
    int n = 0;
    exp_w_q.push_back({wa, d, be});
    bus.data_valid_i = 1'b1;
    bus.data_i       = d;
    bus.be_i         = be;
    bus.data_last_i  = last;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = bus.data_ready_o;
      @(posedge clk);
      #1;
      n++;
    end
    bus.data_valid_i = 1'b0;
    bus.data_last_i  = 1'b0;
    tests++;
    if (!hs) begin
      fails++;
      $display("FAIL flit_timeout got no handshake exp handshake");
    end else begin
      tests++;
      if ({mem_we_o, mem_addr_o} !== {1'b1, wa}) begin
        fails++;
        $display("FAIL flit_write_timing got we=%0d addr=%h exp we=1 addr=%h", mem_we_o, mem_addr_o, wa);
      end
    end
  endtask

  task automatic run_txn(input logic [AW-1:0] a, input int len, input logic [IW-1:0] id, input bit bad_last);
    int w;
    logic [WAW-1:0] base;
    base = a[AW-1:OW];
    send_hdr(a, LW'(len), id, w);
    for (int i = 0; i <= len; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
      send_flit(base + WAW'(i), {$urandom, $urandom}, BW'($urandom), (i == len) ^ bad_last);
    end
    exp_r_q.push_back({id, bad_last});
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_w_q.size() != 0 || exp_r_q.size() != 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests++;
    if (exp_w_q.size() != 0 || exp_r_q.size() != 0) begin
      fails++;
      $display("FAIL drain got pending writes=%0d resps=%0d exp 0/0", exp_w_q.size(), exp_r_q.size());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({bus.req_ready_o, bus.data_ready_o, bus.resp_valid_o, mem_we_o, busy_o, dbg_state_o} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl got %b exp 000000",
               {bus.req_ready_o, bus.data_ready_o, bus.resp_valid_o, mem_we_o, busy_o, dbg_state_o});
    end
    tests++;
    if ({mem_addr_o, mem_wdata_o, mem_be_o, bus.resp_id_o, bus.resp_error_o} !== '0) begin
      fails++;
      $display("FAIL reset_data got addr=%h data=%h be=%h id=%0d err=%0d exp all 0",
               mem_addr_o, mem_wdata_o, mem_be_o, bus.resp_id_o, bus.resp_error_o);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if ({bus.req_ready_o, busy_o, dbg_state_o} !== 3'b100) begin
      fails++;
      $display("FAIL post_reset got req_rdy/busy/state=%b exp 100", {bus.req_ready_o, busy_o, dbg_state_o});
    end
  endtask

  task automatic test_basic();
    int w;
    send_hdr(64'h1000, 8'd3, 4'd5, w);
    for (int i = 0; i < 4; i++)
      send_flit(WAW'(64'h200 + i), {$urandom, $urandom}, BW'($urandom), (i == 3));
    exp_r_q.push_back({4'd5, 1'b0});
    tests++;
    if ({bus.resp_valid_o, bus.resp_id_o, bus.resp_error_o} !== {1'b1, 4'd5, 1'b0}) begin
      fails++;
      $display("FAIL basic_resp got valid=%0d id=%0d err=%0d exp valid=1 id=5 err=0",
               bus.resp_valid_o, bus.resp_id_o, bus.resp_error_o);
    end
    @(posedge clk);
    #1;
    tests++;
    if (mem_we_o !== 1'b0) begin
      fails++;
      $display("FAIL basic_we_pulse got we=%0d exp 0", mem_we_o);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int w;
    send_hdr(64'h300, 8'd0, 4'd2, w);
    send_flit(WAW'(64'h60), {$urandom, $urandom}, BW'($urandom), 1'b1);
    exp_r_q.push_back({4'd2, 1'b0});
    send_hdr(64'h308, 8'd0, 4'd3, w);
    tests++;
    if (w !== 0) begin
      fails++;
      $display("FAIL b2b_hdr_latency got waits=%0d exp 0", w);
    end
    send_flit(WAW'(64'h61), {$urandom, $urandom}, BW'($urandom), 1'b1);
    exp_r_q.push_back({4'd3, 1'b0});
    wait_drain();
  endtask

  task automatic test_fifo_full();
    int w;
    bus.resp_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) run_txn(AW'(64'h100 * i), 0, IW'(i), 1'b0);
    tests++;
    if ({bus.resp_valid_o, bus.resp_id_o} !== {1'b1, 4'd0}) begin
      fails++;
      $display("FAIL full_head got valid=%0d id=%0d exp valid=1 id=0", bus.resp_valid_o, bus.resp_id_o);
    end
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 64'h800;
    bus.req_len_i   = 8'd0;
    bus.req_id_i    = 4'd4;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if ({bus.req_ready_o, busy_o} !== 2'b01) begin
        fails++;
        $display("FAIL full_stall got req_rdy/busy=%b exp 01", {bus.req_ready_o, busy_o});
      end
    end
    @(posedge clk);
    #1;
    bus.resp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (bus.req_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL full_release got req_rdy=%0d exp 1", bus.req_ready_o);
    end
    send_hdr(64'h800, 8'd0, 4'd4, w);
    tests++;
    if (w !== 0) begin
      fails++;
      $display("FAIL full_hdr_latency got waits=%0d exp 0", w);
    end
    send_flit(WAW'(64'h100), {$urandom, $urandom}, BW'($urandom), 1'b1);
    exp_r_q.push_back({4'd4, 1'b0});
    wait_drain();
  endtask

  task automatic test_last_error();
    run_txn(64'h2000, 1, 4'd6, 1'b1);
    wait_drain();
  endtask

  task automatic test_reset_mid();
    int w;
    send_hdr(64'h40, 8'd3, 4'd7, w);
    send_flit(WAW'(64'h8), {$urandom, $urandom}, BW'($urandom), 1'b0);
    send_flit(WAW'(64'h9), {$urandom, $urandom}, BW'($urandom), 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    tests++;
    if ({bus.req_ready_o, bus.data_ready_o, bus.resp_valid_o, mem_we_o, busy_o, dbg_state_o} !== 6'b0) begin
      fails++;
      $display("FAIL midrst_ctrl got %b exp 000000",
               {bus.req_ready_o, bus.data_ready_o, bus.resp_valid_o, mem_we_o, busy_o, dbg_state_o});
    end
    tests++;
    if ({mem_addr_o, mem_wdata_o, mem_be_o} !== '0) begin
      fails++;
      $display("FAIL midrst_mem got addr=%h data=%h be=%h exp 0", mem_addr_o, mem_wdata_o, mem_be_o);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if ({bus.req_ready_o, bus.resp_valid_o, busy_o, dbg_state_o} !== 4'b1000) begin
      fails++;
      $display("FAIL midrst_idle got req_rdy/resp_v/busy/state=%b exp 1000",
               {bus.req_ready_o, bus.resp_valid_o, busy_o, dbg_state_o});
    end
    run_txn(64'h80, 0, 4'd9, 1'b0);
    wait_drain();
  endtask

  task automatic test_wrap();
    run_txn(64'hFFFF_FFFF_FFFF_FFFF, 1, 4'hA, 1'b0);
    wait_drain();
  endtask

  task automatic test_random();
    for (int t = 0; t < 5; t++)
      run_txn({$urandom, $urandom}, $urandom_range(0, 5), IW'($urandom), 1'($urandom_range(0, 1)));
    wait_drain();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.req_valid_i  = 1'b0;
    bus.req_addr_i   = '0;
    bus.req_len_i    = '0;
    bus.req_id_i     = '0;
    bus.data_valid_i = 1'b0;
    bus.data_i       = '0;
    bus.be_i         = '0;
    bus.data_last_i  = 1'b0;
    bus.resp_ready_i = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_fifo_full();
    test_last_error();
    test_reset_mid();
    test_wrap();
    test_random();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
